// File: rtl/msx_bus_if.sv
// rtl/msx_bus_if.sv - filtered MSX bus strobes in, single-cycle transaction events out
interface msx_bus_if #(
  parameter int ADDR_W = 16
) ();
  logic              sltsl_n;
  logic              mreq_n;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic              cyc_ack;
  logic              cyc_valid;
  logic              cyc_io;
  logic              cyc_wr;
  logic [ADDR_W-1:0] cyc_addr;
  logic [7:0]        cyc_wdata;
  logic              wait_n;
  logic              busy;
  logic              timeout;
  logic              aborted;

  modport master (
    output sltsl_n, mreq_n, iorq_n, rd_n, wr_n, addr, din, cyc_ack,
    input  cyc_valid, cyc_io, cyc_wr, cyc_addr, cyc_wdata, wait_n, busy, timeout, aborted
  );

  modport slave (
    input  sltsl_n, mreq_n, iorq_n, rd_n, wr_n, addr, din, cyc_ack,
    output cyc_valid, cyc_io, cyc_wr, cyc_addr, cyc_wdata, wait_n, busy, timeout, aborted
  );
endinterface

// File: rtl/msx_bus_cycle.sv
// rtl/msx_bus_cycle.sv - MSX bus cycle decoder with settle filter, WAIT insertion, timeout and abort
// A decode must hold SETTLE_CYCLES samples before one event fires; the access then stays latched until the strobes drop.
module msx_bus_cycle #(
  parameter int ADDR_W        = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int WAIT_MAX      = 255
) (
  input logic       clk,
  input logic       reset,
  msx_bus_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(WAIT_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [1:0]        kind_q, kind_d;
  logic              valid_q, valid_d;
  logic              wait_n_q, wait_n_d;
  logic              timeout_q, timeout_d;
  logic              aborted_q, aborted_d;
  logic              io_q, io_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic       dec_mem, dec_io, dec_rd, dec_wr, dec_ok, released, latch;
  logic [1:0] dec_kind;
  logic [SW-1:0] scnt_inc;
  logic [WW-1:0] wcnt_inc;

  // sltsl_n only qualifies memory cycles; I/O decodes regardless of slot
  assign dec_mem  = ~bus.sltsl_n & ~bus.mreq_n;
  assign dec_io   = ~bus.iorq_n;
  assign dec_rd   = ~bus.rd_n & bus.wr_n;
  assign dec_wr   = ~bus.wr_n & bus.rd_n;
  assign dec_ok   = (dec_mem ^ dec_io) & (dec_rd ^ dec_wr);
  assign dec_kind = {dec_io, dec_wr};
  assign released = bus.rd_n & bus.wr_n;
  assign scnt_inc = scnt_q + SW'(1);
  assign wcnt_inc = wcnt_q + WW'(1);

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    wcnt_d    = wcnt_q;
    kind_d    = kind_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    aborted_d = 1'b0;
    wait_n_d  = wait_n_q;
    io_d      = io_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    latch     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dec_ok) begin
          kind_d = dec_kind;
          scnt_d = SW'(1);
          if (SW'(1) == SETTLE_LAST) latch = 1'b1;
          else state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (dec_ok && dec_kind == kind_q) begin
          scnt_d = scnt_inc;
          if (scnt_inc == SETTLE_LAST) latch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_inc;
        if (bus.cyc_ack) begin
          wait_n_d = 1'b1;
          state_d  = S_DONE;
        end else if (released) begin
          wait_n_d  = 1'b1;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (wcnt_inc == WAIT_LAST) begin
          wait_n_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: begin
        // DONE: the strobe must drop before another access can be decoded
        wait_n_d = 1'b1;
        if (released) state_d = S_IDLE;
      end
    endcase

    if (latch) begin
      io_d     = dec_kind[1];
      wr_d     = dec_kind[0];
      addr_d   = bus.addr;
      wdata_d  = dec_kind[0] ? bus.din : 8'h00;
      valid_d  = 1'b1;
      wait_n_d = 1'b0;
      wcnt_d   = '0;
      state_d  = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      scnt_q    <= '0;
      wcnt_q    <= '0;
      kind_q    <= 2'b00;
      valid_q   <= 1'b0;
      wait_n_q  <= 1'b1;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
      io_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      wcnt_q    <= wcnt_d;
      kind_q    <= kind_d;
      valid_q   <= valid_d;
      wait_n_q  <= wait_n_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
      io_q      <= io_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.cyc_valid = valid_q;
  assign bus.cyc_io    = io_q;
  assign bus.cyc_wr    = wr_q;
  assign bus.cyc_addr  = addr_q;
  assign bus.cyc_wdata = wdata_q;
  assign bus.wait_n    = wait_n_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_msx_bus_cycle.sv
// tb/tb_msx_bus_cycle.sv - self-checking bench for msx_bus_cycle
module tb_msx_bus_cycle;
  localparam int SETTLE = 2;
  localparam int WMAX   = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  msx_bus_if #(.ADDR_W(16)) bus ();
  msx_bus_cycle #(.ADDR_W(16), .SETTLE_CYCLES(SETTLE), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n_valid;
    int          valid_tick;
    int          low;
    int          n_to;
    int          n_ab;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        io;
    logic        wr;
    logic        done_busy;
    logic        idle_busy;
    logic        hung;
  } obs_t;

  typedef struct {
    int low;
    int to;
    int ab;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.sltsl_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
    bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.addr = 16'h0000; bus.din = 8'h00; bus.cyc_ack = 1'b0;
  endtask

  task automatic drive(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d);
    bus.sltsl_n = io ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.mreq_n  = io;
    bus.iorq_n  = !io;
    bus.rd_n    = wr;
    bus.wr_n    = !wr;
    bus.addr    = a;
    bus.din     = d;
  endtask

  // Ack wins over abort in the same cycle, abort wins over timeout; WAIT spans one cycle per waited edge.
  function automatic exp_t model(input int ack_at, input int abort_at, input bit ack_hold);
    exp_t e;
    int ak, ab;
    ak = ack_hold ? 0 : ((ack_at < 0) ? 1000 : ack_at);
    ab = (abort_at < 0) ? 1000 : abort_at;
    e = '{default: 0};
    if (ak < WMAX && ak <= ab) e.low = ak + 1;
    else if (ab < WMAX) begin e.low = ab + 1; e.ab = 1; end
    else begin e.low = WMAX; e.to = 1; end
    return e;
  endfunction

  task automatic run_txn(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d,
                         input int ack_at, input int abort_at, input bit ack_hold,
                         input int hold_after, output obs_t o);
    int end_t, rel_t;
    bit ended, released;
    o = '{default: 0};
    o.hung = 1'b1;
    ended = 0; released = 0; end_t = 0; rel_t = 0;
    bus.cyc_ack = ack_hold;
    drive(io, wr, a, d);
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (bus.cyc_valid) begin
        o.n_valid++;
        if (o.n_valid == 1) begin
          o.valid_tick = t; o.addr = bus.cyc_addr; o.wdata = bus.cyc_wdata;
          o.io = bus.cyc_io; o.wr = bus.cyc_wr;
        end
      end
      if (!bus.wait_n) o.low++;
      if (bus.timeout) o.n_to++;
      if (bus.aborted) o.n_ab++;
      if (o.n_valid > 0 && !ended && bus.wait_n) begin ended = 1; end_t = t; end
      if (o.n_valid > 0 && !ended) begin
        bus.cyc_ack = ack_hold || (t - o.valid_tick == ack_at);
        if (t - o.valid_tick == abort_at && !released) begin
          bus.rd_n = 1'b1; bus.wr_n = 1'b1; released = 1; rel_t = t; o.done_busy = bus.busy;
        end
      end else if (ended) begin
        bus.cyc_ack = ack_hold;
        if (!released && t - end_t >= hold_after) begin
          bus.rd_n = 1'b1; bus.wr_n = 1'b1; released = 1; rel_t = t; o.done_busy = bus.busy;
        end else if (released && t >= rel_t + 2 && t >= end_t + 1) begin
          o.idle_busy = bus.busy; o.hung = 1'b0;
          break;
        end
      end
    end
    bus_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    tick(); tick();
    checks++;
    if ({bus.cyc_valid, bus.wait_n, bus.busy, bus.timeout, bus.aborted, bus.cyc_io, bus.cyc_wr} !== 7'b0100000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0100000",
               {bus.cyc_valid, bus.wait_n, bus.busy, bus.timeout, bus.aborted, bus.cyc_io, bus.cyc_wr});
    end
    checks++;
    if (bus.cyc_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.cyc_addr); end
    checks++;
    if (bus.cyc_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", bus.cyc_wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mem_write();
    obs_t o;
    run_txn(1'b0, 1'b1, 16'h4000, 8'hA5, 2, -1, 1'b0, 2, o);
    checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL memwr_hang: got %b want 0", o.hung); end
    checks++; if (o.n_valid != 1) begin errors++; $display("FAIL memwr_valid_count: got %0d want 1", o.n_valid); end
    checks++; if (o.valid_tick != SETTLE) begin errors++; $display("FAIL memwr_latency: got %0d want %0d", o.valid_tick, SETTLE); end
    checks++; if ({o.io, o.wr} !== 2'b01) begin errors++; $display("FAIL memwr_kind: got %b want 01", {o.io, o.wr}); end
    checks++; if (o.addr !== 16'h4000) begin errors++; $display("FAIL memwr_addr: got %h want 4000", o.addr); end
    checks++; if (o.wdata !== 8'hA5) begin errors++; $display("FAIL memwr_wdata: got %h want a5", o.wdata); end
    checks++; if (o.low != 3) begin errors++; $display("FAIL memwr_wait_low: got %0d want 3", o.low); end
    checks++; if (bus.cyc_addr !== 16'h4000) begin errors++; $display("FAIL memwr_addr_hold: got %h want 4000", bus.cyc_addr); end
  endtask

  task automatic test_io_read();
    obs_t o;
    run_txn(1'b1, 1'b0, 16'h0098, 8'h5C, -1, -1, 1'b1, 3, o);
    checks++; if (o.n_valid != 1) begin errors++; $display("FAIL ioread_valid_count: got %0d want 1", o.n_valid); end
    checks++; if ({o.io, o.wr} !== 2'b10) begin errors++; $display("FAIL ioread_kind: got %b want 10", {o.io, o.wr}); end
    checks++; if (o.addr !== 16'h0098) begin errors++; $display("FAIL ioread_addr: got %h want 0098", o.addr); end
    checks++; if (o.wdata !== 8'h00) begin errors++; $display("FAIL ioread_wdata: got %h want 00", o.wdata); end
    checks++; if (o.low != 1) begin errors++; $display("FAIL ioread_wait_low: got %0d want 1", o.low); end
    checks++; if (o.done_busy !== 1'b1) begin errors++; $display("FAIL ioread_done_busy: got %b want 1", o.done_busy); end
    checks++; if (o.idle_busy !== 1'b0) begin errors++; $display("FAIL ioread_idle: got %b want 0", o.idle_busy); end
  endtask

  task automatic test_glitch();
    int nv, nl;
    logic settle_busy;
    nv = 0; nl = 0;
    drive(1'b0, 1'b0, 16'h8000, 8'h00);
    tick();
    settle_busy = bus.busy;
    bus.rd_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (bus.cyc_valid) nv++;
      if (!bus.wait_n) nl++;
      tick();
    end
    checks++; if (settle_busy !== 1'b1) begin errors++; $display("FAIL glitch_settle_busy: got %b want 1", settle_busy); end
    checks++; if (nv != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", nv); end
    checks++; if (nl != 0) begin errors++; $display("FAIL glitch_wait: got %0d want 0", nl); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", bus.busy); end
    bus_idle();
    tick();
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, -1, -1, 1'b0, 3, o);
    checks++; if (o.low != WMAX) begin errors++; $display("FAIL timeout_wait_low: got %0d want %0d", o.low, WMAX); end
    checks++; if (o.n_to != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", o.n_to); end
    checks++; if (o.n_valid != 1) begin errors++; $display("FAIL timeout_no_retrigger: got %0d want 1", o.n_valid); end
    checks++; if (o.n_ab != 0) begin errors++; $display("FAIL timeout_abort: got %0d want 0", o.n_ab); end
  endtask

  task automatic test_abort();
    obs_t o;
    run_txn(1'b0, 1'b1, 16'hC001, 8'h3E, -1, 1, 1'b0, 0, o);
    checks++; if (o.n_ab != 1) begin errors++; $display("FAIL abort_pulse: got %0d want 1", o.n_ab); end
    checks++; if (o.low != 2) begin errors++; $display("FAIL abort_wait_low: got %0d want 2", o.low); end
    checks++; if (o.n_to != 0) begin errors++; $display("FAIL abort_timeout: got %0d want 0", o.n_to); end
    checks++; if (o.idle_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", o.idle_busy); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    drive(1'b1, 1'b1, 16'h00A0, 8'h77);
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      if (bus.cyc_valid) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_valid: got 0 want 1"); end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.cyc_valid, bus.wait_n, bus.busy, bus.timeout, bus.aborted, bus.cyc_io, bus.cyc_wr} !== 7'b0100000) begin
      errors++;
      $display("FAIL rstmid_flags: got %b want 0100000",
               {bus.cyc_valid, bus.wait_n, bus.busy, bus.timeout, bus.aborted, bus.cyc_io, bus.cyc_wr});
    end
    checks++;
    if ({bus.cyc_addr, bus.cyc_wdata} !== 24'h0) begin
      errors++; $display("FAIL rstmid_data: got %h want 000000", {bus.cyc_addr, bus.cyc_wdata});
    end
    bus_idle();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_illegal();
    int nv, nb;
    for (int p = 0; p < 3; p++) begin
      nv = 0; nb = 0;
      bus_idle();
      bus.addr = 16'hBEEF;
      case (p)
        0: begin bus.sltsl_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0; end
        1: begin bus.sltsl_n = 1'b0; bus.mreq_n = 1'b0; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
        default: begin bus.sltsl_n = 1'b1; bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
      endcase
      for (int t = 0; t < 5; t++) begin
        tick();
        if (bus.cyc_valid) nv++;
        if (bus.busy) nb++;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL illegal%0d_valid: got %0d want 0", p, nv); end
      checks++; if (nb != 0) begin errors++; $display("FAIL illegal%0d_busy: got %0d want 0", p, nb); end
      bus_idle();
      tick();
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit io, wr;
    logic [15:0] a;
    logic [7:0] d;
    int ack_at, abort_at, sel;
    for (int i = 0; i < 30; i++) begin
      io = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      a = 16'($urandom); d = 8'($urandom);
      sel = $urandom_range(0, 3);
      ack_at   = (sel == 0 || sel == 2) ? $urandom_range(0, WMAX) : -1;
      abort_at = (sel == 1) ? $urandom_range(0, WMAX - 1) : (sel == 2) ? $urandom_range(0, WMAX) : -1;
      e = model(ack_at, abort_at, 1'b0);
      run_txn(io, wr, a, d, ack_at, abort_at, 1'b0, $urandom_range(0, 3), o);
      checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL rnd%0d_hang: got %b want 0", i, o.hung); end
      checks++; if (o.n_valid != 1) begin errors++; $display("FAIL rnd%0d_valid: got %0d want 1", i, o.n_valid); end
      checks++; if (o.valid_tick != SETTLE) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.valid_tick, SETTLE); end
      checks++; if ({o.io, o.wr} !== {io, wr}) begin errors++; $display("FAIL rnd%0d_kind: got %b want %b", i, {o.io, o.wr}, {io, wr}); end
      checks++; if (o.addr !== a) begin errors++; $display("FAIL rnd%0d_addr: got %h want %h", i, o.addr, a); end
      checks++; if (o.wdata !== (wr ? d : 8'h00)) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o.wdata, wr ? d : 8'h00); end
      checks++; if (o.low != e.low) begin errors++; $display("FAIL rnd%0d_wait_low: got %0d want %0d", i, o.low, e.low); end
      checks++; if (o.n_to != e.to) begin errors++; $display("FAIL rnd%0d_timeout: got %0d want %0d", i, o.n_to, e.to); end
      checks++; if (o.n_ab != e.ab) begin errors++; $display("FAIL rnd%0d_aborted: got %0d want %0d", i, o.n_ab, e.ab); end
      checks++; if (o.idle_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got %b want 0", i, o.idle_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_io_read();
    test_glitch();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
